// File: rtl/sub_shift_rows_seq_pkg.sv
// Shared AES definitions for the SubBytes/ShiftRows stage.
//   STATE_W / COL_W : width of one AES state and of one state column
//   state_t         : FSM state encoding (IDLE, RUN, DONE)
//   byte_lsb()      : bit position of byte (row, col) inside a column-major state
//   col_lsb()       : bit position of column col inside a column-major state
package sub_shift_rows_seq_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte (row r, column c) lives at bits [127-32c-8r -: 8], so its lsb is 120-32c-8r.
  function automatic logic [6:0] byte_lsb(input logic [1:0] row, input logic [1:0] col);
    return 7'd120 - {col, 5'b00000} - {2'b00, row, 3'b000};
  endfunction

  // Column c lives at bits [127-32c -: 32], so its lsb is 96-32c.
  function automatic logic [6:0] col_lsb(input logic [1:0] col);
    return 7'd96 - {col, 5'b00000};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational.
//   a : input byte
//   y : substituted byte
// The table is derived arithmetically: multiplicative inverse in GF(2^8)
// (x^254, which also maps 0 to 0) followed by the standard affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ xx;
      xx = xtime(xx);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    y   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/sub_shift_rows_seq.sv
// AES SubBytes followed by ShiftRows, one output column per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, a state is accepted on an edge where both are 1
//   in_data             : AES state, column-major, byte (r,c) at [127-32c-8r -: 8]
//   out_valid/out_ready : output handshake, result is consumed on an edge where both are 1
//   out_data            : registered SubBytes+ShiftRows result, same layout as in_data
//   dbg_state           : current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid, once raised by this block, and its data stay unchanged until that edge.
//
// Flow: IDLE captures the state, RUN spends four cycles computing column 0..3
// through four shared S-boxes, DONE holds the result until the consumer takes it.
module sub_shift_rows_seq
  import sub_shift_rows_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic [1:0]         dbg_state
);

  state_t             state;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] cap;
  logic [7:0]         sb_in  [4];
  logic [7:0]         sb_out [4];
  logic [COL_W-1:0]   col_out;

  // ShiftRows: output byte (r,c) reads input byte (r,c+r); the 2-bit add wraps mod 4.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      sb_in[r] = cap[byte_lsb(2'(r), cnt + 2'(r)) +: 8];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sb_in[g]),
      .y (sb_out[g])
    );
  end

  // Row 0 occupies the most significant byte of a column.
  assign col_out   = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      cap       <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap      <= in_data;
            cnt      <= 2'd0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          out_data[col_lsb(cnt) +: COL_W] <= col_out;
          // Increment wraps 3 -> 0 exactly on the move to DONE.
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 2'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
module tb_sub_shift_rows_seq;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   dbg_state;

  logic [127:0] exp_q[$];
  int           n_checks;
  int           n_fails;
  int           n_out;

  sub_shift_rows_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_TAB;
    return t[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d);
    logic [127:0] res;
    logic [7:0]   src;
    int           sc;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc  = (c + r) % 4;
        src = d[127 - 32 * sc - 8 * r -: 8];
        res[127 - 32 * c - 8 * r -: 8] = sbox_ref(src);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_ready_wait", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(tag, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int      sent;
    int      cyc;
    logic    rdy_s;
    n_checks  = 0;
    n_fails   = 0;
    n_out     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_state",     128'(dbg_state), 128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data",  out_data,        128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // scoreboard monitor: compare every consumed output against the queue head
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) chk("spurious_out", 128'(exp_q.size()), 128'd1);
          else chk("out_data", out_data, exp_q.pop_front());
        end
      end
    join_none

    // FIPS-197 vector and latency: out_valid in the 5th cycle, for one cycle
    out_ready = 1'b1;
    send(FIPS_IN, FIPS_OUT);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_c%0d", k), 128'(out_valid), (k == 5) ? 128'd1 : 128'd0);
      if (k == 1) chk("lat_run_state", 128'(dbg_state), 128'd1);
      if (k == 5) chk("lat_done_state", 128'(dbg_state), 128'd2);
    end
    chk("lat_back_idle", 128'(dbg_state), 128'd0);
    wait_drain("drain_fips");

    // all 0x53 -> all 0xed
    send({16{8'h53}}, {16{8'hed}});
    wait_drain("drain_53");

    // backpressure on the all-zero vector
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send('0, {16{8'h63}});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_valid_rise", 128'(out_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_data",  out_data, {16{8'h63}});
      chk("bp_in_ready",   128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle",  128'(dbg_state), 128'd0);
    chk("bp_release_ready", 128'(in_ready),  128'd1);
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    wait_drain("drain_bp");

    // input noise during RUN and DONE must not be captured
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(FIPS_IN, FIPS_OUT);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand128();
    end
    @(negedge clk);
    chk("noise_done_valid", 128'(out_valid), 128'd1);
    chk("noise_done_ready", 128'(in_ready),  128'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand128();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("noise_idle_state", 128'(dbg_state), 128'd0);
    chk("noise_idle_ready", 128'(in_ready),  128'd1);
    chk("noise_queue_empty", 128'(exp_q.size()), 128'd0);
    repeat (6) @(negedge clk);
    chk("noise_no_second", 128'(out_valid), 128'd0);

    // reset while RUN with counter=2 discards the partial result
    send(FIPS_IN, FIPS_OUT);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_run", 128'(dbg_state), 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_state",     128'(dbg_state), 128'd0);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_data",  out_data,        128'd0);
    chk("abort_in_ready",  128'(in_ready),  128'd1);
    send(FIPS_IN, FIPS_OUT);
    wait_drain("drain_after_abort");

    // 100 random states with random out_ready
    sent = 0;
    cyc  = 0;
    while ((sent < 100 || exp_q.size() > 0) && cyc < 6000) begin
      @(negedge clk);
      rdy_s = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy_s) begin
        exp_q.push_back(ref_model(in_data));
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 100 && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_data  = rand128();
      end
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", 128'(sent), 128'd100);
    wait_drain("drain_rand");
    repeat (10) @(negedge clk);
    chk("total_outputs", 128'(n_out), 128'd105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sub_shift_rows_seq.md
SUB_SHIFT_ROWS_SEQ -- requirements
Module: sub_shift_rows_seq

Interface
REQ-001 Parameters: none.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  in_data holds a valid AES state.
REQ-006 in_ready  output  1  block can accept a state this cycle.
REQ-007 in_data  input  128  AES state, column-major: byte (row r, column c) at bits [127-32c-8r -: 8].
REQ-008 out_valid  output  1  out_data holds a completed result.
REQ-009 out_ready  input  1  downstream (MixColumns stage) accepts out_data.
REQ-010 out_data  output  128  SubBytes then ShiftRows of the accepted state, same byte layout as in_data.

Function
REQ-011 The output byte (r,c) SHALL equal sbox(input byte (r,(c+r) mod 4)), where sbox is the FIPS-197 forward S-box.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, with in_valid=1, the block SHALL capture in_data into an internal 128-bit register, clear the column counter to 0 and go to RUN on the same edge.
REQ-015 In RUN, each cycle SHALL produce one output column c = counter using exactly four S-box instances, write it into out_data column c and increment the counter.
REQ-016 In RUN with counter=3, the block SHALL write column 3 and go to DONE.
REQ-017 Latency: out_valid SHALL rise in the 5th cycle after the accepting edge; throughput is at most one state per 6 cycles.
REQ-018 In DONE, out_data and out_valid SHALL hold stable until out_ready=1; on out_valid and out_ready the block SHALL return to IDLE.
REQ-019 in_valid SHALL be ignored outside IDLE; in_data SHALL have no effect except on the accepting edge.
REQ-020 In DONE with out_ready=1 and in_valid=1, the block SHALL NOT accept input that cycle; in_ready is 0.
REQ-021 The column counter SHALL be 2 bits and wrap only through the RUN to DONE transition; no other wrap-around SHALL occur.
REQ-022 out_data SHALL be driven directly from a register, with no combinational path from in_data to out_data.

Reset
REQ-023 With rst_n=0 at a rising edge, state SHALL become IDLE, the counter 0, out_data 128'h0 and the captured register 128'h0.
REQ-024 After reset, in_ready=1 and out_valid=0 from the first cycle.
REQ-025 A reset in RUN or DONE SHALL abort the transfer; the partial result SHALL be discarded and never presented.

Structure
REQ-026 The shared AES package SHALL hold the state-width constant (128), the byte/column index helpers and the FSM state enum.
REQ-027 The S-box SHALL be the sub-module aes_sbox (8-bit in, 8-bit out, combinational), instantiated four times, so a later key-expansion block can reuse it.
REQ-028 The ShiftRows byte selection SHALL be combinational muxing by counter, feeding the S-box inputs.

Verification
REQ-029 FIPS-197 vector: in_data=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_valid in the 5th cycle after acceptance, high for one cycle.
REQ-030 in_data=all zero -> out_data=6363...63 (16 bytes); in_data=all 0x53 -> out_data=all 0xed.
REQ-031 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; release -> IDLE next cycle.
REQ-032 A changing in_valid/in_data during RUN and DONE -> no second capture; the result matches the first state only.
REQ-033 rst_n=0 for one cycle during RUN (counter=2) -> next cycle IDLE, out_valid=0, out_data=0; a new vector then completes correctly.
REQ-034 Back-to-back: 100 random states with random out_ready -> every output matches a reference model, in order, with none dropped or duplicated.
